// File: rtl/sram_scan_driver.sv
// sram_scan_driver
// Host-side master for the SRAM test chip's serial scan chain. A parallel
// command packet is shifted MSB-first into the chip, the SRAM load strobe is
// pulsed, a fixed gap is waited out, and the captured scan word is optionally
// shifted back and returned as a parallel response.
//
// Ports
//   clk          : single clock, all logic on posedge
//   resetn       : synchronous active-low reset
//   cmd_valid    : command offered
//   cmd_ready    : command accepted when cmd_valid && cmd_ready (IDLE only)
//   cmd_pkt      : packet, MSB first: chip_sel, addr0, din0, csb0, web0,
//                  wmask0, addr1, din1, csb1, web1, wmask1
//   cmd_readback : 1 = shift the captured word back after the load
//   rsp_valid    : one-cycle response pulse
//   rsp_data     : captured scan word, 0 when readback was skipped
//   scan_en      : to gpio_scan
//   scan_out     : to gpio_in (serial data toward the chip)
//   scan_in      : from gpio_out (serial data from the chip)
//   sram_load    : to gpio_sram_load
//   global_csb   : global SRAM deselect, active high
module sram_scan_driver #(
    parameter int ADDR_SIZE  = 16,
    parameter int DATA_SIZE  = 32,
    parameter int WMASK_SIZE = 4,
    parameter int LOAD_GAP   = 2,
    parameter int PKT_W      = 4 + 2 * (ADDR_SIZE + DATA_SIZE + 2 + WMASK_SIZE)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [PKT_W-1:0] cmd_pkt,
    input  logic             cmd_readback,
    output logic             rsp_valid,
    output logic [PKT_W-1:0] rsp_data,
    output logic             scan_en,
    output logic             scan_out,
    input  logic             scan_in,
    output logic             sram_load,
    output logic             global_csb
);

    localparam int CNT_W = $clog2(PKT_W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_PKT = CNT_W'(PKT_W);
    localparam logic [CNT_W-1:0] CNT_GAP = CNT_W'(LOAD_GAP);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT    = 3'd1,
        ST_LOAD     = 3'd2,
        ST_GAP      = 3'd3,
        ST_READBACK = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    // One register serves both directions: shifting the packet out leaves it
    // all zeros, so the readback can shift the chip's word into its LSB.
    logic [PKT_W-1:0] scan_r;
    logic             readback_r;
    logic             cmd_ready_r;
    logic             rsp_valid_r;
    logic [PKT_W-1:0] rsp_data_r;
    logic             scan_en_r;
    logic             scan_out_r;
    logic             sram_load_r;
    logic             global_csb_r;

    // Sequencer: state, counter, scan register and every registered output.
    // Outputs are loaded on the edge that enters a state so they line up with it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            scan_r       <= {PKT_W{1'b0}};
            readback_r   <= 1'b0;
            cmd_ready_r  <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= {PKT_W{1'b0}};
            scan_en_r    <= 1'b0;
            scan_out_r   <= 1'b0;
            sram_load_r  <= 1'b0;
            global_csb_r <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready_r) begin
                        // First bit goes straight to the pin; the rest stays queued.
                        state_r     <= ST_SHIFT;
                        scan_r      <= {cmd_pkt[PKT_W-2:0], 1'b0};
                        scan_out_r  <= cmd_pkt[PKT_W-1];
                        scan_en_r   <= 1'b1;
                        readback_r  <= cmd_readback;
                        cnt_r       <= CNT_PKT;
                        cmd_ready_r <= 1'b0;
                    end else begin
                        cmd_ready_r <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    scan_r <= {scan_r[PKT_W-2:0], 1'b0};
                    if (cnt_r == CNT_ONE) begin
                        state_r      <= ST_LOAD;
                        scan_en_r    <= 1'b0;
                        scan_out_r   <= 1'b0;
                        sram_load_r  <= 1'b1;
                        global_csb_r <= 1'b0;
                    end else begin
                        scan_out_r <= scan_r[PKT_W-1];
                        cnt_r      <= cnt_r - CNT_ONE;
                    end
                end
                ST_LOAD: begin
                    state_r     <= ST_GAP;
                    sram_load_r <= 1'b0;
                    cnt_r       <= CNT_GAP;
                end
                ST_GAP: begin
                    if (cnt_r == CNT_ONE) begin
                        global_csb_r <= 1'b1;
                        if (readback_r) begin
                            state_r   <= ST_READBACK;
                            scan_en_r <= 1'b1;
                            cnt_r     <= CNT_PKT;
                        end else begin
                            state_r     <= ST_DONE;
                            rsp_valid_r <= 1'b1;
                            rsp_data_r  <= {PKT_W{1'b0}};
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_READBACK: begin
                    scan_r <= {scan_r[PKT_W-2:0], scan_in};
                    if (cnt_r == CNT_ONE) begin
                        // Last sample is folded in directly so the response is
                        // complete in the DONE cycle.
                        state_r     <= ST_DONE;
                        scan_en_r   <= 1'b0;
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= {scan_r[PKT_W-2:0], scan_in};
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    cmd_ready_r <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet idle.
                    state_r      <= ST_IDLE;
                    cnt_r        <= {CNT_W{1'b0}};
                    cmd_ready_r  <= 1'b0;
                    rsp_valid_r  <= 1'b0;
                    scan_en_r    <= 1'b0;
                    scan_out_r   <= 1'b0;
                    sram_load_r  <= 1'b0;
                    global_csb_r <= 1'b1;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_data   = rsp_data_r;
    assign scan_en    = scan_en_r;
    assign scan_out   = scan_out_r;
    assign sram_load  = sram_load_r;
    assign global_csb = global_csb_r;

endmodule

// File: tb/tb_sram_scan_driver.sv
// Directed bench for sram_scan_driver. Instance dut uses default parameters,
// dut_b uses LOAD_GAP=1. A small chip model per instance shifts scan_out in
// while scan_en is high, records the shifted word at sram_load and replaces it
// with a fixed read word, which it then presents MSB-first on scan_in.
module tb_sram_scan_driver;
    localparam int PKT_W = 112;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic resetn = 1'b0;
    logic cmd_valid = 1'b0, cmd_readback = 1'b0, cmd_ready;
    logic [PKT_W-1:0] cmd_pkt = '0, rsp_data;
    logic rsp_valid, scan_en, scan_out, scan_in, sram_load, global_csb;
    logic cmd_valid_b = 1'b0, cmd_readback_b = 1'b0, cmd_ready_b;
    logic [PKT_W-1:0] cmd_pkt_b = '0, rsp_data_b;
    logic rsp_valid_b, scan_en_b, scan_out_b, scan_in_b, sram_load_b, global_csb_b;

    logic [PKT_W-1:0] rd_word = {80'h0123_4567_89AB_CDEF_FEDC, 32'hA5A5_1234};
    logic [PKT_W-1:0] chip_sr = '0, chip_seen = '0, chip_sr_b = '0, chip_seen_b = '0;

    sram_scan_driver #(.ADDR_SIZE(16), .DATA_SIZE(32), .WMASK_SIZE(4), .LOAD_GAP(2)) dut (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_pkt(cmd_pkt), .cmd_readback(cmd_readback), .rsp_valid(rsp_valid),
        .rsp_data(rsp_data), .scan_en(scan_en), .scan_out(scan_out), .scan_in(scan_in),
        .sram_load(sram_load), .global_csb(global_csb));

    sram_scan_driver #(.ADDR_SIZE(16), .DATA_SIZE(32), .WMASK_SIZE(4), .LOAD_GAP(1)) dut_b (
        .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_pkt(cmd_pkt_b), .cmd_readback(cmd_readback_b), .rsp_valid(rsp_valid_b),
        .rsp_data(rsp_data_b), .scan_en(scan_en_b), .scan_out(scan_out_b), .scan_in(scan_in_b),
        .sram_load(sram_load_b), .global_csb(global_csb_b));

    // Chip-side scan register models.
    assign scan_in   = chip_sr[PKT_W-1];
    assign scan_in_b = chip_sr_b[PKT_W-1];
    always @(posedge clk) begin
        if (sram_load) begin
            chip_seen <= chip_sr;
            chip_sr   <= rd_word;
        end else if (scan_en) begin
            chip_sr <= {chip_sr[PKT_W-2:0], scan_out};
        end
        if (sram_load_b) begin
            chip_seen_b <= chip_sr_b;
            chip_sr_b   <= rd_word;
        end else if (scan_en_b) begin
            chip_sr_b <= {chip_sr_b[PKT_W-2:0], scan_out_b};
        end
    end

    // Offer a command on dut and return the cycle it was accepted in; the
    // packet is replaced with junk right after acceptance.
    task automatic start_cmd(input logic [PKT_W-1:0] pkt, input logic rb, input bit hold,
                             output int t_acc);
        logic [127:0] junk;
        @(negedge clk);
        cmd_pkt = pkt; cmd_readback = rb; cmd_valid = 1'b1;
        t_acc = -1;
        for (int k = 0; k < 400; k++) begin
            if (cmd_ready === 1'b1) begin t_acc = cyc; break; end
            @(negedge clk);
        end
        if (t_acc < 0) begin
            failures++; checks++;
            $display("FAIL accept_timeout: cmd_ready never rose within 400 cycles");
        end
        @(negedge clk);
        junk = {$urandom, $urandom, $urandom, $urandom};
        cmd_pkt = junk[PKT_W-1:0];
        cmd_readback = ~rb;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Observe dut from the current cycle until rsp_valid (bounded).
    task automatic watch(output int n_scan, output int n_load, output int n_csb_lo,
                         output int n_ready, output int t_load, output int t_rsp,
                         output logic [PKT_W-1:0] rsp);
        n_scan = 0; n_load = 0; n_csb_lo = 0; n_ready = 0; t_load = -1; t_rsp = -1; rsp = '0;
        for (int k = 0; k < 300; k++) begin
            if (scan_en === 1'b1) n_scan++;
            if (sram_load === 1'b1) begin n_load++; t_load = cyc; end
            if (global_csb === 1'b0) n_csb_lo++;
            if (cmd_ready === 1'b1) n_ready++;
            if (rsp_valid === 1'b1) begin t_rsp = cyc; rsp = rsp_data; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, global_csb, scan_en, scan_out, sram_load, rsp_valid} !== 6'b010000) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 010000",
                     {cmd_ready, global_csb, scan_en, scan_out, sram_load, rsp_valid});
        end
        checks++;
        if ({cmd_ready_b, global_csb_b, scan_en_b, scan_out_b, sram_load_b, rsp_valid_b} !== 6'b010000) begin
            failures++;
            $display("FAIL reset_outputs_b: got %b want 010000",
                     {cmd_ready_b, global_csb_b, scan_en_b, scan_out_b, sram_load_b, rsp_valid_b});
        end
        checks++;
        if (rsp_data !== '0) begin failures++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write();
        logic [PKT_W-1:0] pkt, rsp;
        int t, n_scan, n_load, n_csb, n_rdy, t_load, t_rsp;
        pkt = {4'h1, 16'h0005, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'hF, 16'h0000, 32'h0, 1'b1, 1'b1, 4'h0};
        start_cmd(pkt, 1'b0, 1'b0, t);
        watch(n_scan, n_load, n_csb, n_rdy, t_load, t_rsp, rsp);
        checks++; if (n_scan !== 112) begin failures++; $display("FAIL wr_scan_cycles: got %0d want 112", n_scan); end
        checks++; if (chip_seen !== pkt) begin failures++; $display("FAIL wr_shifted_word: got %h want %h", chip_seen, pkt); end
        checks++; if (n_load !== 1) begin failures++; $display("FAIL wr_load_width: got %0d want 1", n_load); end
        checks++; if (t_load !== t + 113) begin failures++; $display("FAIL wr_load_time: got %0d want %0d", t_load, t + 113); end
        checks++; if (n_csb !== 3) begin failures++; $display("FAIL wr_csb_low: got %0d want 3", n_csb); end
        checks++; if (n_rdy !== 0) begin failures++; $display("FAIL wr_ready_busy: got %0d want 0", n_rdy); end
        checks++; if (t_rsp !== t + 116) begin failures++; $display("FAIL wr_rsp_time: got %0d want %0d", t_rsp, t + 116); end
        checks++; if (rsp !== '0) begin failures++; $display("FAIL wr_rsp_data: got %h want 0", rsp); end
        @(negedge clk);
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++; $display("FAIL wr_after_done: got %b want 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_loopback();
        logic [PKT_W-1:0] pkt, rsp;
        int t, n_scan, n_load, n_csb, n_rdy, t_load, t_rsp;
        pkt = {4'h2, 16'h0005, 32'h0, 1'b0, 1'b1, 4'h0, 16'h0000, 32'h0, 1'b1, 1'b1, 4'h0};
        start_cmd(pkt, 1'b1, 1'b0, t);
        watch(n_scan, n_load, n_csb, n_rdy, t_load, t_rsp, rsp);
        checks++; if (chip_seen !== pkt) begin failures++; $display("FAIL lb_shifted_word: got %h want %h", chip_seen, pkt); end
        checks++; if (n_scan !== 224) begin failures++; $display("FAIL lb_scan_cycles: got %0d want 224", n_scan); end
        checks++; if (n_csb !== 3) begin failures++; $display("FAIL lb_csb_low: got %0d want 3", n_csb); end
        checks++; if (t_rsp !== t + 228) begin failures++; $display("FAIL lb_rsp_time: got %0d want %0d", t_rsp, t + 228); end
        checks++; if (rsp !== rd_word) begin failures++; $display("FAIL lb_rsp_data: got %h want %h", rsp, rd_word); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== rd_word) begin
            failures++; $display("FAIL lb_rsp_hold: valid %b data %h want 0 / %h", rsp_valid, rsp_data, rd_word);
        end
    endtask

    task automatic test_back_to_back();
        logic [PKT_W-1:0] pkts [3];
        logic rbs [3];
        logic [PKT_W-1:0] rsp, exp_rsp;
        int t, n_scan, n_load, n_csb, n_rdy, t_load, t_rsp, prev_rsp;
        pkts[0] = {4'h3, 16'h1234, 32'h0102_0304, 1'b0, 1'b1, 4'h0, 16'hFFFF, 32'hFFFF_0000, 1'b1, 1'b1, 4'h0};
        pkts[1] = {4'h4, 16'hABCD, 32'hCAFE_F00D, 1'b0, 1'b0, 4'h5, 16'h0001, 32'h8000_0001, 1'b0, 1'b0, 4'hA};
        pkts[2] = {4'h8, 16'h00FF, 32'h5555_AAAA, 1'b1, 1'b1, 4'h0, 16'h7E00, 32'h0F0F_F0F0, 1'b0, 1'b1, 4'h3};
        rbs[0] = 1'b1; rbs[1] = 1'b0; rbs[2] = 1'b1;
        prev_rsp = -1;
        for (int i = 0; i < 3; i++) begin
            start_cmd(pkts[i], rbs[i], 1'b1, t);
            if (i > 0) begin
                checks++;
                if (t !== prev_rsp + 1) begin
                    failures++; $display("FAIL b2b_accept_slot[%0d]: got %0d want %0d", i, t, prev_rsp + 1);
                end
            end
            watch(n_scan, n_load, n_csb, n_rdy, t_load, t_rsp, rsp);
            exp_rsp = rbs[i] ? rd_word : '0;
            checks++; if (chip_seen !== pkts[i]) begin failures++; $display("FAIL b2b_shifted_word[%0d]: got %h want %h", i, chip_seen, pkts[i]); end
            checks++; if (n_rdy !== 0) begin failures++; $display("FAIL b2b_ready_busy[%0d]: got %0d want 0", i, n_rdy); end
            checks++; if (t_rsp !== t + (rbs[i] ? 228 : 116)) begin failures++; $display("FAIL b2b_rsp_time[%0d]: got %0d want %0d", i, t_rsp, t + (rbs[i] ? 228 : 116)); end
            checks++; if (rsp !== exp_rsp) begin failures++; $display("FAIL b2b_rsp_data[%0d]: got %h want %h", i, rsp, exp_rsp); end
            prev_rsp = t_rsp;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [PKT_W-1:0] pkt, rsp;
        int t, n_scan, n_load, n_csb, n_rdy, t_load, t_rsp, n_rsp;
        pkt = {4'h5, 16'h0AAA, 32'h1357_9BDF, 1'b0, 1'b0, 4'hC, 16'h0555, 32'h2468_ACE0, 1'b0, 1'b1, 4'h0};
        // Abort during shift bit 50.
        start_cmd(pkt, 1'b1, 1'b0, t);
        repeat (50) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, global_csb, scan_en, scan_out, sram_load, rsp_valid} !== 6'b010000 || rsp_data !== '0) begin
            failures++; $display("FAIL rst_shift_outputs: got %b data %h want 010000 / 0",
                     {cmd_ready, global_csb, scan_en, scan_out, sram_load, rsp_valid}, rsp_data);
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_shift_ready: got %b want 1", cmd_ready); end
        n_rsp = 0; n_scan = 0;
        repeat (250) begin
            if (rsp_valid === 1'b1) n_rsp++;
            if (scan_en === 1'b1) n_scan++;
            @(negedge clk);
        end
        checks++; if (n_rsp !== 0 || n_scan !== 0) begin failures++; $display("FAIL rst_shift_quiet: rsp %0d scan %0d want 0 0", n_rsp, n_scan); end
        // Abort during readback bit 20.
        start_cmd(pkt, 1'b1, 1'b0, t);
        repeat (135) @(negedge clk);
        checks++; if (scan_en !== 1'b1 || global_csb !== 1'b1) begin failures++; $display("FAIL rst_rb_precond: scan_en %b csb %b want 1 1", scan_en, global_csb); end
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({cmd_ready, global_csb, scan_en, scan_out, sram_load, rsp_valid} !== 6'b010000) begin
            failures++; $display("FAIL rst_rb_outputs: got %b want 010000",
                     {cmd_ready, global_csb, scan_en, scan_out, sram_load, rsp_valid});
        end
        resetn = 1'b1;
        n_rsp = 0;
        repeat (150) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) n_rsp++;
        end
        checks++; if (n_rsp !== 0) begin failures++; $display("FAIL rst_rb_no_rsp: got %0d want 0", n_rsp); end
        // Next command runs normally.
        start_cmd(pkt, 1'b1, 1'b0, t);
        watch(n_scan, n_load, n_csb, n_rdy, t_load, t_rsp, rsp);
        checks++; if (chip_seen !== pkt) begin failures++; $display("FAIL rst_next_word: got %h want %h", chip_seen, pkt); end
        checks++; if (t_rsp !== t + 228) begin failures++; $display("FAIL rst_next_time: got %0d want %0d", t_rsp, t + 228); end
        checks++; if (rsp !== rd_word) begin failures++; $display("FAIL rst_next_data: got %h want %h", rsp, rd_word); end
    endtask

    task automatic test_boundary();
        logic [PKT_W-1:0] ones_pkt, rsp;
        int t, n_scan, n_ones, n_csb, t_load, t_rb, t_rsp;
        ones_pkt = {PKT_W{1'b1}};
        @(negedge clk);
        cmd_pkt_b = ones_pkt; cmd_readback_b = 1'b1; cmd_valid_b = 1'b1;
        t = -1;
        for (int k = 0; k < 20; k++) begin
            if (cmd_ready_b === 1'b1) begin t = cyc; break; end
            @(negedge clk);
        end
        checks++; if (t < 0) begin failures++; $display("FAIL bnd_accept_timeout: no cmd_ready_b within 20 cycles"); end
        @(negedge clk);
        cmd_valid_b = 1'b0; cmd_pkt_b = '0;
        n_scan = 0; n_ones = 0; n_csb = 0; t_load = -1; t_rb = -1; t_rsp = -1; rsp = '0;
        for (int k = 0; k < 300; k++) begin
            if (scan_en_b === 1'b1 && t_load < 0) begin
                n_scan++;
                if (scan_out_b === 1'b1) n_ones++;
            end
            if (scan_en_b === 1'b1 && t_load >= 0 && t_rb < 0) t_rb = cyc;
            if (sram_load_b === 1'b1) t_load = cyc;
            if (global_csb_b === 1'b0) n_csb++;
            if (rsp_valid_b === 1'b1) begin t_rsp = cyc; rsp = rsp_data_b; break; end
            @(negedge clk);
        end
        checks++; if (n_scan !== 112 || n_ones !== 112) begin failures++; $display("FAIL bnd_ones_shifted: scan %0d ones %0d want 112 112", n_scan, n_ones); end
        checks++; if (chip_seen_b !== ones_pkt) begin failures++; $display("FAIL bnd_shifted_word: got %h want all ones", chip_seen_b); end
        checks++; if (t_load !== t + 113) begin failures++; $display("FAIL bnd_load_time: got %0d want %0d", t_load, t + 113); end
        checks++; if (n_csb !== 2) begin failures++; $display("FAIL bnd_csb_low: got %0d want 2", n_csb); end
        checks++; if (t_rb !== t + 115) begin failures++; $display("FAIL bnd_rb_start: got %0d want %0d", t_rb, t + 115); end
        checks++; if (t_rsp !== t + 227) begin failures++; $display("FAIL bnd_rsp_time: got %0d want %0d", t_rsp, t + 227); end
        checks++; if (rsp !== rd_word) begin failures++; $display("FAIL bnd_rsp_data: got %h want %h", rsp, rd_word); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_loopback();
        test_back_to_back();
        test_reset_mid();
        test_boundary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/sram_scan_driver.md
# sram_scan_driver

Host-side master for the SRAM test chip's serial scan interface. Takes one parallel SRAM command packet, shifts it MSB-first into the test chip's scan register, pulses the SRAM load strobe, waits a programmable gap, then optionally shifts the captured SRAM read data back out and returns it as a parallel response. Used in on-die BIST and as the bench-side driver toward the `gpio_scan` / `gpio_sram_load` / `gpio_in` / `gpio_out` pins.

## Interface
**Parameters**
- `ADDR_SIZE`, 16, SRAM address width per port
- `DATA_SIZE`, 32, SRAM data width per port
- `WMASK_SIZE`, 4, write-mask width per port
- `LOAD_GAP`, 2, idle cycles between the load strobe and readback (≥1)
- `PKT_W`, derived, 4 + 2·(`ADDR_SIZE` + `DATA_SIZE` + 2 + `WMASK_SIZE`) = 112 at defaults

**Ports**
- `clk`  in  1  single clock; all logic on posedge
- `resetn`  in  1  synchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid` && `cmd_ready`
- `cmd_pkt`  in  `PKT_W`  packet, MSB→LSB: chip_sel[3:0], addr0, din0, csb0, web0, wmask0, addr1, din1, csb1, web1, wmask1
- `cmd_readback`  in  1  1 = perform the readback shift
- `rsp_valid`  out  1  one-cycle pulse, response available
- `rsp_data`  out  `PKT_W`  captured scan word; held until the next `rsp_valid`
- `scan_en`  out  1  drives `gpio_scan`
- `scan_out`  out  1  drives `gpio_in` (serial data toward the chip)
- `scan_in`  in  1  from `gpio_out` (serial data from the chip)
- `sram_load`  out  1  drives `gpio_sram_load`
- `global_csb`  out  1  global SRAM deselect; active high

## Operation
- **States:** IDLE, SHIFT, LOAD, GAP, READBACK, DONE.
- **IDLE**
  - `cmd_ready` = 1.
  - On accept: latch `cmd_pkt` into the shift register, latch `cmd_readback`, load the counter with `PKT_W`, go to SHIFT.
- **SHIFT**
  - `scan_en` = 1; `scan_out` = shift-register MSB.
  - Each cycle: shift left by one and decrement the counter.
  - Leave after exactly `PKT_W` cycles, for LOAD.
- **LOAD**
  - One cycle: `sram_load` = 1, `global_csb` = 0, `scan_en` = 0.
  - Then go to GAP with the counter = `LOAD_GAP`.
- **GAP**
  - `global_csb` = 0 for `LOAD_GAP` cycles.
  - Exit to READBACK if `cmd_readback` was latched, else DONE.
- **READBACK**
  - `scan_en` = 1, `scan_out` = 0.
  - Each cycle: sample `scan_in` into the capture register LSB, shifting left.
  - Runs `PKT_W` cycles; the first sample is the chip's MSB.
- **DONE**
  - One cycle: `rsp_valid` = 1, then return to IDLE.
  - `rsp_data` = capture register, or 0 if readback was skipped.
- `global_csb` = 1 in every state except LOAD and GAP.
- Counter width: $clog2(`PKT_W`+1). No wrap: each state exits when the counter reaches 1, before it can reach 0.
- No backpressure on the response. A new command can be accepted only in IDLE, i.e. the cycle after DONE at the earliest.
- `cmd_valid` outside IDLE is ignored; `cmd_pkt` need not be held after acceptance.
- Reset (any state, including mid-shift or readback), applied the next edge:
  - state → IDLE
  - `scan_en`, `scan_out`, `sram_load`, `rsp_valid` → 0
  - `global_csb` → 1
  - `rsp_data` and the shift/capture registers → 0
  - `cmd_ready` → 0 while `resetn` is low
- Partial transfers are abandoned; no response is produced for them.

## Timing
- Accept edge T. SHIFT occupies cycles T+1 … T+`PKT_W`. LOAD is at T+`PKT_W`+1.
- GAP occupies the next `LOAD_GAP` cycles.
- READBACK occupies the following `PKT_W` cycles.
- `rsp_valid` cycle:
  - with readback: T+2·`PKT_W`+`LOAD_GAP`+2 (= T+228 at defaults)
  - without readback: T+`PKT_W`+`LOAD_GAP`+2 (= T+116)
- `cmd_ready` rises in the cycle after `rsp_valid`.
- All outputs are registered. `cmd_ready` is decoded from the state register only, with no combinational path from `cmd_valid`.

## Test plan
- **Reset values:** hold `resetn`=0 for 3 cycles → `cmd_ready`=0, `global_csb`=1, and all other outputs 0. Release → `cmd_ready`=1 on the next cycle.
- **Write, no readback:** `cmd_pkt` = chip_sel 1, addr0 0x0005, din0 0xDEADBEEF, csb0 0, web0 0, wmask0 0xF, port 1 idle (csb1 1), `cmd_readback`=0. Required:
  - `scan_out` reproduces the packet MSB-first over 112 cycles with `scan_en`=1
  - `sram_load` high for exactly 1 cycle, with `global_csb` low for 3 cycles
  - `rsp_valid` at T+116 with `rsp_data`=0
- **Loopback readback:** tie `scan_in` to a 112-bit scoreboard model returning 0x…A5A5_1234 (LSBs), with the MSB presented first → `rsp_data` equals the model word exactly, and `rsp_valid` at T+228.
- **Back-to-back:** `cmd_valid` held high with 3 queued commands → each accepted only in IDLE, a 1-cycle `cmd_ready` gap after each DONE, and no packet bits lost or duplicated.
- **Reset mid-operation:** `resetn`=0 at shift bit 50, then again during READBACK bit 20 → IDLE next edge, no `rsp_valid`, `global_csb`=1. The next command completes normally.
- **Boundary:** `LOAD_GAP`=1 and an all-ones packet → exactly 112 ones shifted, GAP lasts 1 cycle, and `rsp_valid` at T+227.
